// File: rtl/tlb_op_ctrl.sv
// TLB maintenance sequencer: runs TLBP/TLBR/TLBWI/TLBWR against the tlb block,
// owns CP0.Random and reports probe/read results back to CP0.
package tlb_op_pkg;

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic [11:0] pagemask;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;

endpackage

module tlb_op_ctrl
  import tlb_op_pkg::*;
#(
  parameter int unsigned TLB_NUM = 16,
  parameter int unsigned IDX_W   = $clog2(TLB_NUM)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [1:0]       op_type,
  output logic             op_ready,
  input  logic [IDX_W-1:0] cp0_index,
  input  logic [IDX_W-1:0] cp0_wired,
  input  logic             cp0_wired_we,
  input  tlb_entry_t       cp0_entry,
  input  logic [31:0]      cp0_entry_hi,
  output logic [IDX_W-1:0] random_out,
  output logic [31:0]      tlbp_key,
  input  logic             tlbp_found,
  input  logic [IDX_W-1:0] tlbp_index,
  output logic [IDX_W-1:0] r_index,
  input  tlb_entry_t       r_entry,
  output logic             we,
  output logic [IDX_W-1:0] w_index,
  output tlb_entry_t       w_entry,
  output logic             done,
  output logic             index_we,
  output logic             index_p,
  output logic [IDX_W-1:0] index_val,
  output logic             entry_we,
  output tlb_entry_t       rd_entry,
  output logic             tlb_flush
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TLB_NUM - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    OP_TLBP  = 2'd0,
    OP_TLBR  = 2'd1,
    OP_TLBWI = 2'd2,
    OP_TLBWR = 2'd3
  } op_t;

  state_t state;
  op_t    op_q;

  // Reload on Wired write or on reaching the wired floor; a floor at or above
  // the last index therefore pins Random at TLB_NUM-1.
  always_ff @(posedge clk) begin
    if (reset || cp0_wired_we || (random_out <= cp0_wired)) begin
      random_out <= LAST_IDX;
    end else begin
      random_out <= random_out - 1'b1;
    end
  end

  // Request fields are captured straight into the tlb-facing registers at
  // accept, so later input changes cannot reach the tlb mid-op.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      op_q      <= OP_TLBP;
      op_ready  <= 1'b1;
      we        <= 1'b0;
      done      <= 1'b0;
      index_we  <= 1'b0;
      entry_we  <= 1'b0;
      tlb_flush <= 1'b0;
      index_p   <= 1'b0;
      index_val <= '0;
      rd_entry  <= '0;
      r_index   <= '0;
      w_index   <= '0;
      w_entry   <= '0;
      tlbp_key  <= '0;
    end else begin
      we        <= 1'b0;
      done      <= 1'b0;
      index_we  <= 1'b0;
      entry_we  <= 1'b0;
      tlb_flush <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (op_valid && op_ready) begin
            op_q     <= op_t'(op_type);
            state    <= S_EXEC;
            op_ready <= 1'b0;
            unique case (op_t'(op_type))
              OP_TLBP: tlbp_key <= cp0_entry_hi;
              OP_TLBR: r_index  <= cp0_index;
              OP_TLBWI: begin
                w_index <= cp0_index;
                w_entry <= cp0_entry;
                we      <= 1'b1;
              end
              OP_TLBWR: begin
                w_index <= random_out;
                w_entry <= cp0_entry;
                we      <= 1'b1;
              end
            endcase
          end
        end
        S_EXEC: begin
          state <= S_DONE;
          done  <= 1'b1;
          unique case (op_q)
            OP_TLBP: begin
              index_we  <= 1'b1;
              index_p   <= ~tlbp_found;
              index_val <= tlbp_found ? tlbp_index : '0;
            end
            OP_TLBR: begin
              entry_we <= 1'b1;
              rd_entry <= r_entry;
            end
            OP_TLBWI, OP_TLBWR: tlb_flush <= 1'b1;
          endcase
        end
        S_DONE: begin
          state    <= S_IDLE;
          op_ready <= 1'b1;
        end
        default: begin
          state    <= S_IDLE;
          op_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
